// File: rtl/univ_shift_reg_burst.sv
// Universal shift register with counted burst repeat.
// Manual ops apply every edge; a burst latches op/count and replays it.
module univ_shift_reg_burst #(
  parameter int DW = 8,
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          sync_rst,
  input  logic [2:0]    ctrl,
  input  logic [DW-1:0] data,
  input  logic          data_l,
  input  logic          data_h,
  input  logic          start,
  input  logic [CW-1:0] cnt,
  output logic [DW-1:0] q,
  output logic          so,
  output logic          busy,
  output logic          done
);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] q_q, q_d;
  logic          so_q, so_d;
  logic          done_q, done_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;

  logic [2:0]    op_sel;
  logic [DW-1:0] res;
  logic          res_so;
  logic          accept;
  logic          last;
  logic          run;

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      so_q    <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      so_q    <= so_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
    end
  end

  // hold/load codes never open a burst
  always_comb begin
    run    = (state_q == ST_RUN);
    op_sel = run ? op_q : ctrl;
    accept = !run && start &&
             (ctrl != 3'b000) &&
             (ctrl != 3'b011) &&
             (ctrl != 3'b111);
    last   = (cnt_q == CW'(1));
  end

  always_comb begin
    res    = q_q;
    res_so = so_q;
    case (op_sel)
      3'b001: begin
        res    = {data_h, q_q[DW-1:1]};
        res_so = q_q[0];
      end
      3'b010: begin
        res    = {q_q[DW-2:0], data_l};
        res_so = q_q[DW-1];
      end
      3'b011: res = data;
      3'b100: begin
        res    = {q_q[0], q_q[DW-1:1]};
        res_so = q_q[0];
      end
      3'b101: begin
        res    = {q_q[DW-2:0], q_q[DW-1]};
        res_so = q_q[DW-1];
      end
      3'b110: begin
        res    = {q_q[DW-1], q_q[DW-1:1]};
        res_so = q_q[0];
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    if (!run) begin
      if (accept && (cnt != '0))
        state_d = ST_RUN;
    end else if (last) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    q_d    = q_q;
    so_d   = so_q;
    cnt_d  = cnt_q;
    op_d   = op_q;
    done_d = 1'b0;
    if (run) begin
      q_d    = res;
      so_d   = res_so;
      cnt_d  = cnt_q - CW'(1);
      done_d = last;
    end else if (accept) begin
      op_d   = ctrl;
      cnt_d  = cnt;
      done_d = (cnt == '0);
    end else begin
      q_d  = res;
      so_d = res_so;
    end
  end

  assign q    = q_q;
  assign so   = so_q;
  assign busy = run;
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// Directed scoreboard bench for univ_shift_reg_burst at
// three widths: 8/4, 4/2 and 16/5.
module tb_univ_shift_reg_burst;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  ctrl;
  logic        start;
  logic [4:0]  cnt;
  logic        dl, dh;
  logic [7:0]  data8;
  logic [3:0]  data4;
  logic [15:0] data16;

  logic [7:0]  q8;
  logic        so8, busy8, done8;
  logic [3:0]  q4;
  logic        so4, busy4, done4;
  logic [15:0] q16;
  logic        so16, busy16, done16;

  always #5 clk = ~clk;

  univ_shift_reg_burst #(.DW(8), .CW(4)) u8 (
    .clk(clk), .sync_rst(rst), .ctrl(ctrl),
    .data(data8), .data_l(dl), .data_h(dh),
    .start(start), .cnt(cnt[3:0]),
    .q(q8), .so(so8), .busy(busy8), .done(done8)
  );

  univ_shift_reg_burst #(.DW(4), .CW(2)) u4 (
    .clk(clk), .sync_rst(rst), .ctrl(ctrl),
    .data(data4), .data_l(dl), .data_h(dh),
    .start(start), .cnt(cnt[1:0]),
    .q(q4), .so(so4), .busy(busy4), .done(done4)
  );

  univ_shift_reg_burst #(.DW(16), .CW(5)) u16 (
    .clk(clk), .sync_rst(rst), .ctrl(ctrl),
    .data(data16), .data_l(dl), .data_h(dh),
    .start(start), .cnt(cnt),
    .q(q16), .so(so16), .busy(busy16), .done(done16)
  );

  typedef struct {
    string       tag;
    int          u;
    logic [15:0] q;
    logic        so;
    logic        busy;
    logic        done;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;

  task automatic push(input string tag, input int u,
                      input logic [15:0] eq, input logic es,
                      input logic eb, input logic ed);
    exp_t e;
    e.tag = tag;
    e.u = u;
    e.q = eq;
    e.so = es;
    e.busy = eb;
    e.done = ed;
    sb.push_back(e);
  endtask

  task automatic drv(input logic r, input logic [2:0] c,
                     input logic s, input logic [4:0] n);
    rst = r;
    ctrl = c;
    start = s;
    cnt = n;
  endtask

  task automatic step();
    exp_t e;
    logic [15:0] oq;
    logic os, ob, od;
    @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      if (e.u == 0) begin
        oq = {8'h00, q8};
        os = so8; ob = busy8; od = done8;
      end else if (e.u == 1) begin
        oq = {12'h000, q4};
        os = so4; ob = busy4; od = done4;
      end else begin
        oq = q16;
        os = so16; ob = busy16; od = done16;
      end
      total++;
      assert (oq === e.q) else begin
        bad++;
        $error("FAIL %s q obs=%h exp=%h", e.tag, oq, e.q);
      end
      total++;
      assert (os === e.so) else begin
        bad++;
        $error("FAIL %s so obs=%b exp=%b", e.tag, os, e.so);
      end
      total++;
      assert (ob === e.busy) else begin
        bad++;
        $error("FAIL %s busy obs=%b exp=%b",
               e.tag, ob, e.busy);
      end
      total++;
      assert (od === e.done) else begin
        bad++;
        $error("FAIL %s done obs=%b exp=%b",
               e.tag, od, e.done);
      end
    end
  endtask

  initial begin
    logic [15:0] eq;
    dl = 1'b0;
    dh = 1'b0;
    data8 = 8'hA5;
    data4 = 4'h1;
    data16 = 16'h0001;

    // 8-bit: reset beats load, then manual ops
    drv(1, 3'b011, 0, 0);
    push("rst", 0, 16'h00, 0, 0, 0); step();
    drv(0, 3'b011, 0, 0);
    push("load", 0, 16'hA5, 0, 0, 0); step();
    drv(0, 3'b010, 0, 0); dl = 1'b1;
    push("shl", 0, 16'h4B, 1, 0, 0); step();
    drv(0, 3'b001, 0, 0); dh = 1'b0;
    push("shr", 0, 16'h25, 1, 0, 0); step();
    drv(0, 3'b011, 0, 0);
    push("reload", 0, 16'hA5, 1, 0, 0); step();

    // rotate-right burst, busy-time start/ctrl ignored
    drv(0, 3'b100, 1, 3);
    push("rr_acc", 0, 16'hA5, 1, 1, 0); step();
    drv(0, 3'b101, 1, 7);
    push("rr1", 0, 16'hD2, 1, 1, 0); step();
    push("rr2", 0, 16'h69, 0, 1, 0); step();
    drv(0, 3'b110, 1, 1);
    push("rr3", 0, 16'hB4, 1, 0, 1); step();
    push("b2b_acc", 0, 16'hB4, 1, 1, 0); step();
    drv(0, 3'b000, 0, 0);
    push("b2b_asr", 0, 16'hDA, 0, 0, 1); step();

    // arithmetic burst then zero count
    data8 = 8'h90;
    drv(0, 3'b011, 0, 0);
    push("ld90", 0, 16'h90, 0, 0, 0); step();
    drv(0, 3'b110, 1, 2);
    push("asr_acc", 0, 16'h90, 0, 1, 0); step();
    drv(0, 3'b000, 0, 0);
    push("asr1", 0, 16'hC8, 0, 1, 0); step();
    push("asr2", 0, 16'hE4, 0, 0, 1); step();
    drv(0, 3'b001, 1, 0);
    push("cnt0", 0, 16'hE4, 0, 0, 1); step();
    drv(0, 3'b000, 0, 0);
    push("cnt0_after", 0, 16'hE4, 0, 0, 0); step();

    // start with load/hold acts as manual
    data8 = 8'h3C;
    drv(0, 3'b011, 1, 5);
    push("st_load", 0, 16'h3C, 0, 0, 0); step();
    drv(0, 3'b000, 1, 5);
    push("st_hold", 0, 16'h3C, 0, 0, 0); step();

    // reset at second shifting edge of a cnt=5 burst
    drv(0, 3'b101, 1, 5);
    push("rl_acc", 0, 16'h3C, 0, 1, 0); step();
    drv(0, 3'b000, 0, 0);
    push("rl1", 0, 16'h78, 0, 1, 0); step();
    drv(1, 3'b000, 0, 0);
    push("mid_rst", 0, 16'h00, 0, 0, 0); step();
    drv(0, 3'b000, 0, 0);
    for (int i = 0; i < 5; i++) begin
      push("no_resume", 0, 16'h00, 0, 0, 0); step();
    end

    // live serial input during burst
    data8 = 8'h00;
    drv(0, 3'b011, 0, 0);
    push("ld00", 0, 16'h00, 0, 0, 0); step();
    drv(0, 3'b010, 1, 2); dl = 1'b1;
    push("sl_acc", 0, 16'h00, 0, 1, 0); step();
    drv(0, 3'b000, 0, 0);
    push("sl1", 0, 16'h01, 0, 1, 0); step();
    dl = 1'b0;
    push("sl2", 0, 16'h02, 0, 0, 1); step();

    // 4-bit / 2-bit count: max burst of 3
    drv(1, 3'b000, 0, 0);
    push("rst4", 1, 16'h0, 0, 0, 0); step();
    drv(0, 3'b011, 0, 0);
    push("ld4", 1, 16'h1, 0, 0, 0); step();
    drv(0, 3'b101, 1, 3);
    push("acc4", 1, 16'h1, 0, 1, 0); step();
    drv(0, 3'b000, 0, 0);
    push("rl4_1", 1, 16'h2, 0, 1, 0); step();
    push("rl4_2", 1, 16'h4, 0, 1, 0); step();
    push("rl4_3", 1, 16'h8, 0, 0, 1); step();
    push("hold4", 1, 16'h8, 0, 0, 0); step();

    // 16-bit / 5-bit count: max burst of 31
    drv(1, 3'b000, 0, 0);
    push("rst16", 2, 16'h0, 0, 0, 0); step();
    drv(0, 3'b011, 0, 0);
    push("ld16", 2, 16'h0001, 0, 0, 0); step();
    drv(0, 3'b101, 1, 31);
    push("acc16", 2, 16'h0001, 0, 1, 0); step();
    drv(0, 3'b000, 0, 0);
    for (int i = 1; i <= 31; i++) begin
      eq = 16'h0001 << (i % 16);
      push("rl16", 2, eq, (i == 16), (i != 31), (i == 31));
      step();
    end
    push("hold16", 2, 16'h8000, 0, 0, 0); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
